// File: rtl/pc_pkg.sv
// Shared types and constants for the PC/fetch stage: next-PC source encoding,
// default trap vectors and the exception return-address register index.
package pc_pkg;

   typedef enum logic [1:0] {
      PC_SEQ = 2'd0,
      PC_BR  = 2'd1,
      PC_J   = 2'd2,
      PC_JR  = 2'd3
   } pc_sel_t;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;
   localparam logic [31:0] IRQ_VECTOR_DEF   = 32'h8000_0004;
   localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0008;
   localparam int          K0_REG           = 26;

   // Branch offset is in words; scale to bytes and add to pc+4 (wraps mod 2^32).
   function automatic logic [31:0] br_target(input logic [31:0] pc_plus4,
                                             input logic [15:0] imm16);
      logic signed [31:0] off;
      off = {{14{imm16[15]}}, imm16, 2'b00};
      return pc_plus4 + off;
   endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: decoder/control inputs towards pc_fetch and the PC/trap
// outputs back to the ROM, regfile and datapath.
interface pc_fetch_if;
   import pc_pkg::*;

   logic          stall;
   pc_sel_t       pc_sel;
   logic          branch_taken;
   logic [15:0]   imm16;
   logic [25:0]   jtarget;
   logic [31:0]   jr_addr;
   logic          irq;
   logic          exc;

   logic [31:0]   pc;
   logic [31:0]   pc_plus4;
   logic          kernel;
   logic          xp_we;
   logic [31:0]   xp_data;
   logic          flush;
   logic          irq_ack;

   modport master (
      output stall, pc_sel, branch_taken, imm16, jtarget, jr_addr, irq, exc,
      input  pc, pc_plus4, kernel, xp_we, xp_data, flush, irq_ack
   );

   modport slave (
      input  stall, pc_sel, branch_taken, imm16, jtarget, jr_addr, irq, exc,
      output pc, pc_plus4, kernel, xp_we, xp_data, flush, irq_ack
   );

endinterface

// File: rtl/irq_sync.sv
// Two-flop synchronizer for asynchronous level inputs, cleared by the
// synchronous reset so no stale level survives a reset.
module irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and next-PC selection with interrupt/exception entry,
// $k0 return-address write and flush of the preempted instruction.
module pc_fetch
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [31:0] IRQ_VECTOR   = IRQ_VECTOR_DEF,
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   pc_fetch_if.slave   bus
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] normal_pc;
   logic        kernel;
   logic        irq_s;
   logic        exc_take;
   logic        irq_take;

   irq_sync u_irq_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (bus.irq),
      .sync_o  (irq_s)
   );

   assign pc_plus4 = pc_q + 32'd4;
   assign kernel   = pc_q[31];

   // Traps are only accepted in an unstalled user cycle; exception outranks irq.
   always_comb begin
      exc_take = 1'b0;
      irq_take = 1'b0;
      if (!reset && !bus.stall && !kernel) begin
         exc_take = bus.exc;
         irq_take = irq_s & ~bus.exc;
      end
   end

   always_comb begin
      normal_pc = pc_plus4;
      case (bus.pc_sel)
         PC_SEQ: normal_pc = pc_plus4;
         PC_BR:  normal_pc = bus.branch_taken ? br_target(pc_plus4, bus.imm16) : pc_plus4;
         PC_J:   normal_pc = {pc_plus4[31:28], bus.jtarget, 2'b00};
         // User code may not reach kernel space through a register jump.
         PC_JR:  normal_pc = kernel ? bus.jr_addr : {1'b0, bus.jr_addr[30:0]};
         default: normal_pc = pc_plus4;
      endcase
   end

   always_comb begin
      pc_d = normal_pc;
      if (reset)         pc_d = RESET_VECTOR;
      else if (bus.stall) pc_d = pc_q;
      else if (exc_take) pc_d = EXC_VECTOR;
      else if (irq_take) pc_d = IRQ_VECTOR;
   end

   always_ff @(posedge clk) begin
      pc_q <= pc_d;
   end

   assign bus.pc       = pc_q;
   assign bus.pc_plus4 = pc_plus4;
   assign bus.kernel   = kernel;
   assign bus.xp_we    = exc_take | irq_take;
   assign bus.xp_data  = pc_plus4;
   assign bus.flush    = exc_take | irq_take;
   assign bus.irq_ack  = irq_take;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: the driver queues the expected per-cycle
// outputs, and an independent monitor compares them on the falling edge.
module tb_pc_fetch;
   import pc_pkg::*;

   logic clk;
   logic reset;
   int   cyc;
   int   n_chk;
   int   n_fail;

   pc_fetch_if bus ();

   pc_fetch u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      int          cyc;
      string       name;
      logic [31:0] pc;
      logic        kernel;
      logic        xp_we;
      logic        flush;
      logic        irq_ack;
      logic [31:0] xp_data;
   } exp_t;

   exp_t sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string n, input logic [31:0] pc,
                             input logic k, input logic trap, input logic ack);
      exp_t e;
      e.cyc     = cyc;
      e.name    = n;
      e.pc      = pc;
      e.kernel  = k;
      e.xp_we   = trap;
      e.flush   = trap;
      e.irq_ack = ack;
      e.xp_data = pc + 32'd4;
      sb.push_back(e);
   endtask

   task automatic drive(input pc_sel_t sel, input logic [31:0] jr,
                        input logic [25:0] jt, input logic [15:0] imm, input logic bt);
      bus.pc_sel       = sel;
      bus.jr_addr      = jr;
      bus.jtarget      = jt;
      bus.imm16        = imm;
      bus.branch_taken = bt;
   endtask

   // Monitor: compare every queued expectation whose cycle has come.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_chk++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: sampled in cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
         end else if (bus.pc !== e.pc || bus.kernel !== e.kernel || bus.xp_we !== e.xp_we ||
                      bus.flush !== e.flush || bus.irq_ack !== e.irq_ack ||
                      bus.xp_data !== e.xp_data || bus.pc_plus4 !== e.pc + 32'd4) begin
            n_fail++;
            $display("FAIL %s: got pc=%h k=%b we=%b fl=%b ack=%b xd=%h p4=%h, need pc=%h k=%b we=%b fl=%b ack=%b xd=%h",
                     e.name, bus.pc, bus.kernel, bus.xp_we, bus.flush, bus.irq_ack,
                     bus.xp_data, bus.pc_plus4, e.pc, e.kernel, e.xp_we, e.flush,
                     e.irq_ack, e.xp_data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      bus.stall = 1'b0;
      bus.irq   = 1'b0;
      bus.exc   = 1'b0;
      drive(PC_SEQ, 32'h0, 26'h0, 16'h0, 1'b0);

      step(); step();
      expect_now("reset_state", 32'h8000_0000, 1'b1, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      expect_now("seq0", 32'h8000_0000, 1'b1, 1'b0, 1'b0);
      step(); expect_now("seq1", 32'h8000_0004, 1'b1, 1'b0, 1'b0);
      step(); expect_now("seq2", 32'h8000_0008, 1'b1, 1'b0, 1'b0);

      // Kernel jr into user space, then jumps and branches.
      drive(PC_JR, 32'h0040_0000, 26'h0, 16'h0, 1'b0);
      step(); expect_now("jr_kernel", 32'h0040_0000, 1'b0, 1'b0, 1'b0);
      drive(PC_J, 32'h0, 26'h010_000C, 16'h0, 1'b0);
      step(); expect_now("jump", 32'h0040_0030, 1'b0, 1'b0, 1'b0);
      drive(PC_BR, 32'h0, 26'h0, 16'hFFFD, 1'b1);
      step(); expect_now("br_taken", 32'h0040_0028, 1'b0, 1'b0, 1'b0);
      drive(PC_BR, 32'h0, 26'h0, 16'hFFFD, 1'b0);
      step(); expect_now("br_not_taken", 32'h0040_002C, 1'b0, 1'b0, 1'b0);
      drive(PC_J, 32'h0, 26'h010_0004, 16'h0, 1'b0);
      step(); expect_now("jump2", 32'h0040_0010, 1'b0, 1'b0, 1'b0);
      drive(PC_JR, 32'h8000_0000, 26'h0, 16'h0, 1'b0);
      step(); expect_now("jr_user_mask", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      drive(PC_J, 32'h0, 26'h010_0008, 16'h0, 1'b0);
      step();
      drive(PC_SEQ, 32'h0, 26'h0, 16'h0, 1'b0);
      bus.irq = 1'b1;
      expect_now("irq_raise", 32'h0040_0020, 1'b0, 1'b0, 1'b0);

      // Interrupt path through the synchronizer.
      step(); expect_now("irq_sync1", 32'h0040_0024, 1'b0, 1'b0, 1'b0);
      step(); expect_now("irq_take", 32'h0040_0028, 1'b0, 1'b1, 1'b1);
      step(); expect_now("irq_vector", 32'h8000_0004, 1'b1, 1'b0, 1'b0);
      step(); expect_now("irq_held_kernel", 32'h8000_0008, 1'b1, 1'b0, 1'b0);

      // Exception and interrupt in the same user cycle.
      drive(PC_JR, 32'h0040_0040, 26'h0, 16'h0, 1'b0);
      step();
      drive(PC_SEQ, 32'h0, 26'h0, 16'h0, 1'b0);
      bus.exc = 1'b1;
      expect_now("exc_wins", 32'h0040_0040, 1'b0, 1'b1, 1'b0);
      step();
      bus.exc = 1'b0;
      drive(PC_JR, 32'h0040_0044, 26'h0, 16'h0, 1'b0);
      expect_now("exc_vector", 32'h8000_0008, 1'b1, 1'b0, 1'b0);
      step();
      drive(PC_SEQ, 32'h0, 26'h0, 16'h0, 1'b0);
      expect_now("irq_after_ret", 32'h0040_0044, 1'b0, 1'b1, 1'b1);
      step();
      drive(PC_JR, 32'h0040_0050, 26'h0, 16'h0, 1'b0);
      expect_now("irq_vector2", 32'h8000_0004, 1'b1, 1'b0, 1'b0);

      // Stall blocks the pending interrupt and holds the PC.
      step();
      bus.stall = 1'b1;
      bus.exc   = 1'b1;
      expect_now("stall_hold", 32'h0040_0050, 1'b0, 1'b0, 1'b0);
      step();
      bus.exc = 1'b0;
      expect_now("stall_hold2", 32'h0040_0050, 1'b0, 1'b0, 1'b0);
      step();
      bus.stall = 1'b0;
      drive(PC_SEQ, 32'h0, 26'h0, 16'h0, 1'b0);
      bus.irq = 1'b0;
      expect_now("stall_release", 32'h0040_0050, 1'b0, 1'b1, 1'b1);
      step();
      drive(PC_JR, 32'h0040_0060, 26'h0, 16'h0, 1'b0);
      expect_now("irq_vector3", 32'h8000_0004, 1'b1, 1'b0, 1'b0);
      step();
      drive(PC_SEQ, 32'h0, 26'h0, 16'h0, 1'b0);
      expect_now("user_no_irq", 32'h0040_0060, 1'b0, 1'b0, 1'b0);

      // Mid-run reset overrides a pending exception and clears the synchronizer.
      step();
      reset   = 1'b1;
      bus.exc = 1'b1;
      bus.irq = 1'b1;
      expect_now("reset_forces_zero", 32'h0040_0064, 1'b0, 1'b0, 1'b0);
      step();
      reset   = 1'b0;
      bus.exc = 1'b0;
      drive(PC_JR, 32'h0040_0070, 26'h0, 16'h0, 1'b0);
      expect_now("reset_mid", 32'h8000_0000, 1'b1, 1'b0, 1'b0);
      step();
      drive(PC_SEQ, 32'h0, 26'h0, 16'h0, 1'b0);
      expect_now("post_reset_no_ack", 32'h0040_0070, 1'b0, 1'b0, 1'b0);
      step();
      bus.irq = 1'b0;
      expect_now("post_reset_take", 32'h0040_0074, 1'b0, 1'b1, 1'b1);

      // Address arithmetic wraps modulo 2^32.
      step();
      drive(PC_JR, 32'hFFFF_FFFC, 26'h0, 16'h0, 1'b0);
      expect_now("irq_vector4", 32'h8000_0004, 1'b1, 1'b0, 1'b0);
      step();
      drive(PC_SEQ, 32'h0, 26'h0, 16'h0, 1'b0);
      expect_now("wrap_pre", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
      step(); expect_now("wrap", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

      step(); step();
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch-control stage of the single-cycle MIPS core. It sits directly upstream of the instruction ROM: it owns the PC register, drives the ROM word address, and selects the next PC from the sequential, branch, jump, jr, interrupt, exception and reset sources. It also produces the `$k0` return-address write and the flush that cancels the preempted instruction. Kernel mode is encoded as `pc[31]`: kernel code lives at 0x8000_0000, and user code starts at 0x0040_0000.

## Interface
- `RESET_VECTOR`, 32'h8000_0000, PC after reset
- `IRQ_VECTOR`, 32'h8000_0004, interrupt entry
- `EXC_VECTOR`, 32'h8000_0008, exception (undefined instruction) entry
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  hold PC; no interrupt/exception accepted this cycle
- `pc_sel`  in  2  PC_SEQ=0, PC_BR=1, PC_J=2, PC_JR=3 (from decoder)
- `branch_taken`  in  1  branch condition result; used only when pc_sel=PC_BR
- `imm16`  in  16  branch offset, in words, signed
- `jtarget`  in  26  J-format target field
- `jr_addr`  in  32  register value for jr/jalr
- `irq`  in  1  asynchronous level interrupt from the timer peripheral
- `exc`  in  1  undefined instruction in the current cycle (from decoder)
- `pc`  out  32  current PC; drives the ROM address
- `pc_plus4`  out  32  pc+4, for jal link and the datapath
- `kernel`  out  1  equals `pc[31]`
- `xp_we`  out  1  write `xp_data` to register 26 (`$k0`) this cycle
- `xp_data`  out  32  return address, equal to `pc_plus4`
- `flush`  out  1  suppress regfile and memory writes of the current instruction
- `irq_ack`  out  1  one-cycle pulse when an interrupt is taken

## Operation
- Next-PC priority, highest first:
  1. **reset:** load `RESET_VECTOR`.
  2. **stall:** hold the PC.
  3. **exception taken:** condition is `exc & ~kernel`.
  4. **interrupt taken:** condition is `irq_s & ~kernel`.
  5. **normal path:** selected by `pc_sel`.
- Normal sources:
  - **SEQ:** pc+4.
  - **BR:** pc+4+(sext(imm16)<<2) when `branch_taken`, else pc+4.
  - **J:** {pc_plus4[31:28], jtarget, 2'b00}.
  - **JR:** jr_addr. In user mode, bit 31 of the target is forced to 0, so user code cannot enter kernel space by jr.
- All address arithmetic is modulo 2^32, with no overflow detection. 0xFFFF_FFFC+4 wraps to 0.
- When an exception or interrupt is taken:
  - PC loads the corresponding vector.
  - `xp_we`=1, `xp_data`=pc+4, `flush`=1.
  - `irq_ack`=1 for interrupts only.
- Return-address convention:
  - The interrupt handler subtracts 4 from `$k0` and re-executes the preempted instruction.
  - The exception handler returns to `$k0` directly, skipping the faulting instruction.
- While `kernel`=1, `irq` and `exc` are ignored. An `irq` level that is still asserted is taken on the first user-mode, unstalled cycle.
- `irq` passes through a 2-flop synchronizer, cleared by reset; its output is `irq_s`. There is no pending latch, because the source is level-held until the handler clears the timer.

## Timing
- Reset values:
  - `pc`=RESET_VECTOR, `pc_plus4`=RESET_VECTOR+4, `kernel`=1.
  - `xp_we`=0, `flush`=0, `irq_ack`=0.
  - Synchronizer flops = 0.
- While `reset`=1, `xp_we`, `flush` and `irq_ack` are forced to 0.
- Reset asserted mid-operation wins over every other source in that cycle.
- ROM latency is zero. `pc` is registered; `pc_plus4`, `kernel`, `xp_*`, `flush` and `irq_ack` are combinational from the registered `pc`, `irq_s` and the current inputs.
- `irq` latency: `irq` rises before edge N. `irq_s`=1 after edge N+1. The interrupt is taken in that cycle, and PC=IRQ_VECTOR after edge N+2 (stall=0, user mode).
- `exc` and `irq_s` asserted in the same user cycle: the exception wins. `irq_ack`=0, and the interrupt is taken after the handler returns to user mode.
- While `stall`=1:
  - `xp_we`, `flush` and `irq_ack` are 0.
  - The event is evaluated again in the first unstalled cycle.

## Structure
- Package `pc_pkg` contains:
  - the `pc_sel_t` enum (PC_SEQ, PC_BR, PC_J, PC_JR);
  - default vector constants;
  - `K0_REG`=26.
- Sub-module `irq_sync` is the 2-flop synchronizer with synchronous reset, reused by other peripheral inputs.

## Test plan
- **Reset:** release reset with stall=0 and pc_sel=SEQ → pc sequence is 0x8000_0000, 0x8000_0004, 0x8000_0008; kernel=1 throughout.
- **Branch and jump:**
  - pc=0x0040_0030, BR, taken, imm16=0xFFFD → next pc=0x0040_0028.
  - J, jtarget=0x010000C → next pc=0x0040_0030.
- **JR protection:**
  - user pc=0x0040_0010, JR, jr_addr=0x8000_0000 → next pc=0x0000_0000.
  - kernel pc, jr_addr=0x0040_0000 → next pc=0x0040_0000, kernel=0.
- **Interrupt:** user mode at pc=0x0040_0020, irq raised → two cycles later xp_we=1, xp_data=pc+4, flush=1, irq_ack=1; next pc=0x8000_0004. irq held in kernel mode → no further ack.
- **Simultaneous events:** exc=1 and irq_s=1 at pc=0x0040_0040 → pc=0x8000_0008, xp_data=0x0040_0044, irq_ack=0. After jr to user code, the interrupt is taken.
- **Stall and mid-run reset:** stall=1 with irq_s=1 → pc held, all pulses 0. Reset asserted at user pc → next pc=0x8000_0000; the synchronizer is cleared, so there is no ack for the two cycles after reset.
